// File: rtl/register_file_pkg.sv
// Shared register-block constants: address-width derivation and legal-depth check.
package register_file_pkg;

  localparam int REG_DEPTH_MIN = 2;
  localparam int REG_DEPTH_MAX = 64;

  // Address width never drops below one bit, even for a two-entry block.
  function automatic int reg_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit reg_depth_ok(input int depth);
    return (depth >= REG_DEPTH_MIN) && (depth <= REG_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/register_file_param_register.sv
// One storage word: loads INIT on reset, d on write enable.
// Latency: one edge write; backpressure: none.
module param_register #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= INIT;
    end else if (w) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with optional hardwired-zero reg 0 and write forwarding.
// Latency: write one edge, reads combinational; backpressure: none, illegal writes flagged on err.
module register_file
  import register_file_pkg::*;
#(
  parameter int               WIDTH    = 10,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] INIT     = '0,
  parameter bit               ZERO_REG = 1'b0,
  parameter bit               FORWARD  = 1'b1,
  localparam int              AW       = reg_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] d,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] qa,
  input  logic [AW-1:0]    rb,
  output logic [WIDTH-1:0] qb,
  output logic             err
);

  if (!reg_depth_ok(DEPTH)) begin : g_depth_check
    $error("register_file: DEPTH %0d outside legal range", DEPTH);
  end

  logic [WIDTH-1:0] q_arr [DEPTH];
  logic             wa_in_range;
  logic             wa_zero_hit;
  logic             wr_legal;
  logic             wr_ok;

  assign wa_in_range = (int'(wa) < DEPTH);
  assign wa_zero_hit = ZERO_REG && (wa == '0);
  assign wr_legal    = wa_in_range && !wa_zero_hit;
  // Reset beats a simultaneous write, which also suppresses forwarding.
  assign wr_ok       = w && !rst && wr_legal;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    param_register #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_reg (
      .d   (d),
      .clk (clk),
      .rst (rst),
      .w   (wr_ok && (wa == AW'(i))),
      .q   (q_arr[i])
    );
  end

  always_comb begin
    qa = '0;
    if ((int'(ra) < DEPTH) && !(ZERO_REG && (ra == '0))) begin
      if (FORWARD && wr_ok && (wa == ra)) begin
        qa = d;
      end else begin
        qa = q_arr[ra];
      end
    end
  end

  always_comb begin
    qb = '0;
    if ((int'(rb) < DEPTH) && !(ZERO_REG && (rb == '0))) begin
      if (FORWARD && wr_ok && (wa == rb)) begin
        qb = d;
      end else begin
        qb = q_arr[rb];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= w && !wr_legal;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: four configurations share one stimulus stream.
module tb_register_file;

  localparam logic [9:0] INIT_V = 10'b1111100000;

  typedef struct {
    logic [1:0] addr;
    logic [9:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       w;
  logic [1:0] wa;
  logic [9:0] d;
  logic [1:0] ra;
  logic [1:0] rb;

  logic [9:0] qa_f, qb_f, qa_n, qb_n, qa_z, qb_z, qa_3, qb_3;
  logic       err_f, err_n, err_z, err_3;

  int   tests_run = 0;
  int   fails     = 0;
  exp_t sb[$];
  exp_t e;

  register_file #(.WIDTH(10), .DEPTH(4), .INIT(INIT_V), .ZERO_REG(1'b0), .FORWARD(1'b1)) u_f (
    .clk(clk), .rst(rst), .w(w), .wa(wa), .d(d), .ra(ra), .qa(qa_f), .rb(rb), .qb(qb_f), .err(err_f));
  register_file #(.WIDTH(10), .DEPTH(4), .INIT(INIT_V), .ZERO_REG(1'b0), .FORWARD(1'b0)) u_n (
    .clk(clk), .rst(rst), .w(w), .wa(wa), .d(d), .ra(ra), .qa(qa_n), .rb(rb), .qb(qb_n), .err(err_n));
  register_file #(.WIDTH(10), .DEPTH(4), .INIT(INIT_V), .ZERO_REG(1'b1), .FORWARD(1'b1)) u_z (
    .clk(clk), .rst(rst), .w(w), .wa(wa), .d(d), .ra(ra), .qa(qa_z), .rb(rb), .qb(qb_z), .err(err_z));
  register_file #(.WIDTH(10), .DEPTH(3), .INIT(INIT_V), .ZERO_REG(1'b0), .FORWARD(1'b1)) u_3 (
    .clk(clk), .rst(rst), .w(w), .wa(wa), .d(d), .ra(ra), .qa(qa_3), .rb(rb), .qb(qb_3), .err(err_3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] exp_z, exp_3;
    rst = 1'b1; w = 1'b0; wa = 2'd0; d = 10'd0; ra = 2'd0; rb = 2'd0;
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      ra = 2'(a); rb = 2'(a);
      #1;
      exp_z = (a == 0) ? 10'd0 : INIT_V;
      exp_3 = (a == 3) ? 10'd0 : INIT_V;
      tests_run++; if (qa_f !== INIT_V || qb_f !== INIT_V) begin fails++; $display("FAIL reset_fwd a=%0d qa=%0d qb=%0d exp=%0d", a, qa_f, qb_f, INIT_V); end
      tests_run++; if (qa_n !== INIT_V || qb_n !== INIT_V) begin fails++; $display("FAIL reset_nofwd a=%0d qa=%0d qb=%0d exp=%0d", a, qa_n, qb_n, INIT_V); end
      tests_run++; if (qa_z !== exp_z || qb_z !== exp_z) begin fails++; $display("FAIL reset_zero a=%0d qa=%0d qb=%0d exp=%0d", a, qa_z, qb_z, exp_z); end
      tests_run++; if (qa_3 !== exp_3 || qb_3 !== exp_3) begin fails++; $display("FAIL reset_d3 a=%0d qa=%0d qb=%0d exp=%0d", a, qa_3, qb_3, exp_3); end
    end
    tests_run++; if ({err_f, err_n, err_z, err_3} !== 4'b0000) begin fails++; $display("FAIL reset_err got=%b exp=0000", {err_f, err_n, err_z, err_3}); end
  endtask

  task automatic test_write_hold();
    w = 1'b1; wa = 2'd1; d = 10'd45; sb.push_back('{2'd1, 10'd45});
    tick();
    wa = 2'd2; d = 10'd54; sb.push_back('{2'd2, 10'd54});
    tick();
    w = 1'b0; wa = 2'd1; d = 10'd100;
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ra = e.addr; rb = e.addr;
      #1;
      tests_run++; if (qa_f !== e.val || qb_f !== e.val) begin fails++; $display("FAIL write_hold_f a=%0d qa=%0d qb=%0d exp=%0d", e.addr, qa_f, qb_f, e.val); end
      tests_run++; if (qa_n !== e.val) begin fails++; $display("FAIL write_hold_n a=%0d qa=%0d exp=%0d", e.addr, qa_n, e.val); end
    end
    tests_run++; if (err_f !== 1'b0) begin fails++; $display("FAIL write_hold_err got=%b exp=0", err_f); end
  endtask

  task automatic test_forward();
    w = 1'b1; wa = 2'd3; d = 10'd101; ra = 2'd3; rb = 2'd2;
    #1;
    tests_run++; if (qa_f !== 10'd101) begin fails++; $display("FAIL fwd_qa got=%0d exp=101", qa_f); end
    tests_run++; if (qb_f !== 10'd54) begin fails++; $display("FAIL fwd_qb got=%0d exp=54", qb_f); end
    tests_run++; if (qa_n !== INIT_V) begin fails++; $display("FAIL nofwd_qa_pre got=%0d exp=%0d", qa_n, INIT_V); end
    tests_run++; if (qb_n !== 10'd54) begin fails++; $display("FAIL nofwd_qb got=%0d exp=54", qb_n); end
    tick();
    w = 1'b0;
    #1;
    tests_run++; if (qa_n !== 10'd101) begin fails++; $display("FAIL nofwd_qa_post got=%0d exp=101", qa_n); end
    tests_run++; if (qa_f !== 10'd101) begin fails++; $display("FAIL fwd_qa_post got=%0d exp=101", qa_f); end
    tests_run++; if (err_3 !== 1'b1 || err_f !== 1'b0) begin fails++; $display("FAIL fwd_err err_3=%b err_f=%b exp=1,0", err_3, err_f); end
    tick();
    tests_run++; if (err_3 !== 1'b0) begin fails++; $display("FAIL fwd_err_clear err_3=%b exp=0", err_3); end
  endtask

  task automatic test_zero_reg();
    w = 1'b1; wa = 2'd0; d = 10'd105; ra = 2'd0; rb = 2'd1;
    #1;
    tests_run++; if (qa_z !== 10'd0) begin fails++; $display("FAIL zero_fwd qa=%0d exp=0", qa_z); end
    tests_run++; if (qa_f !== 10'd105) begin fails++; $display("FAIL zero_cmp_fwd qa=%0d exp=105", qa_f); end
    tick();
    w = 1'b0;
    #1;
    tests_run++; if (qa_z !== 10'd0) begin fails++; $display("FAIL zero_read qa=%0d exp=0", qa_z); end
    tests_run++; if (err_z !== 1'b1) begin fails++; $display("FAIL zero_err got=%b exp=1", err_z); end
    tests_run++; if (qb_z !== 10'd45) begin fails++; $display("FAIL zero_other qb=%0d exp=45", qb_z); end
    tests_run++; if (err_f !== 1'b0) begin fails++; $display("FAIL zero_err_f got=%b exp=0", err_f); end
    tick();
    tests_run++; if (err_z !== 1'b0) begin fails++; $display("FAIL zero_err_clear got=%b exp=0", err_z); end
  endtask

  task automatic test_depth3();
    w = 1'b1; wa = 2'd3; d = 10'd7; ra = 2'd3; rb = 2'd0;
    tick();
    w = 1'b0;
    #1;
    tests_run++; if (qa_3 !== 10'd0) begin fails++; $display("FAIL d3_read3 qa=%0d exp=0", qa_3); end
    tests_run++; if (err_3 !== 1'b1) begin fails++; $display("FAIL d3_err got=%b exp=1", err_3); end
    tests_run++; if (qb_3 !== 10'd105) begin fails++; $display("FAIL d3_reg0 qb=%0d exp=105", qb_3); end
    ra = 2'd1; rb = 2'd2;
    #1;
    tests_run++; if (qa_3 !== 10'd45 || qb_3 !== 10'd54) begin fails++; $display("FAIL d3_others qa=%0d qb=%0d exp=45,54", qa_3, qb_3); end
    tick();
    tests_run++; if (err_3 !== 1'b0) begin fails++; $display("FAIL d3_err_clear got=%b exp=0", err_3); end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; w = 1'b1; wa = 2'd1; d = 10'd0; ra = 2'd1; rb = 2'd1;
    #1;
    tests_run++; if (qa_f !== 10'd45) begin fails++; $display("FAIL rst_nofwd qa=%0d exp=45", qa_f); end
    tick();
    rst = 1'b0; w = 1'b0;
    #1;
    tests_run++; if (qa_f !== INIT_V) begin fails++; $display("FAIL rst_prio qa=%0d exp=%0d", qa_f, INIT_V); end
    tests_run++; if (err_f !== 1'b0) begin fails++; $display("FAIL rst_prio_err got=%b exp=0", err_f); end
    w = 1'b1; d = 10'd0;
    tick();
    w = 1'b0;
    #1;
    tests_run++; if (qa_f !== 10'd0) begin fails++; $display("FAIL rst_then_write qa=%0d exp=0", qa_f); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      w = 1'b1; wa = 2'(i); d = 10'($urandom_range(0, 1023));
      sb.push_back('{2'(i), d});
      tick();
    end
    w = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ra = e.addr; rb = e.addr;
      #1;
      tests_run++; if (qa_f !== e.val || qb_f !== e.val) begin fails++; $display("FAIL b2b_f a=%0d qa=%0d qb=%0d exp=%0d", e.addr, qa_f, qb_f, e.val); end
      tests_run++; if (qa_n !== e.val || qb_n !== e.val) begin fails++; $display("FAIL b2b_n a=%0d qa=%0d qb=%0d exp=%0d", e.addr, qa_n, qb_n, e.val); end
    end
  endtask

  initial begin
    rst = 1'b1; w = 1'b0; wa = '0; d = '0; ra = '0; rb = '0;
    test_reset();
    test_write_hold();
    test_forward();
    test_zero_reg();
    test_depth3();
    test_reset_priority();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 10, data bits per register.
REQ-002 Parameter DEPTH, default 4, number of registers; legal range 2..64.
REQ-003 Parameter INIT, default 0, value every register takes on reset.
REQ-004 Parameter ZERO_REG, default 0; 1 = register 0 reads zero and ignores writes.
REQ-005 Parameter FORWARD, default 1; 1 = same-cycle write data forwarded to read ports.
REQ-006 Localparam AW = clog2(DEPTH), minimum 1, address width.
REQ-007 clk  input  1  single clock, all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 w  input  1  write enable.
REQ-010 wa  input  AW  write address.
REQ-011 d  input  WIDTH  write data.
REQ-012 ra  input  AW  read address, port A.
REQ-013 qa  output  WIDTH  read data, port A, combinational from ra and state.
REQ-014 rb  input  AW  read address, port B.
REQ-015 qb  output  WIDTH  read data, port B, combinational from rb and state.
REQ-016 err  output  1  registered flag: previous cycle attempted an illegal write.

Function
REQ-017 On rising clk with rst=0, w=1 and wa<DEPTH, register[wa] SHALL take d; all other registers hold.
REQ-018 w=0 SHALL leave all registers unchanged.
REQ-019 Write with wa>=DEPTH (non-power-of-two DEPTH) SHALL change no register and set err=1 for one cycle.
REQ-020 Write to register 0 with ZERO_REG=1 SHALL change no register and set err=1 for one cycle.
REQ-021 err SHALL be 0 in any cycle following a legal write, no write, or reset.
REQ-022 qa/qb SHALL equal the addressed register; read address >=DEPTH SHALL return 0.
REQ-023 ZERO_REG=1: reading address 0 SHALL return 0 regardless of INIT or forwarding.
REQ-024 FORWARD=1, w=1, legal wa equal to ra (rb): qa (qb) SHALL equal d in the same cycle.
REQ-025 FORWARD=0: reads SHALL return the pre-edge stored value; new value visible the cycle after the write.
REQ-026 Both ports reading the same address SHALL return identical values.
REQ-027 Write latency SHALL be one clock edge; read latency zero (combinational).

Reset
REQ-028 rst=1 at a rising edge SHALL load INIT into every register (register 0 reads 0 when ZERO_REG=1) and clear err.
REQ-029 rst SHALL take priority over a simultaneous write; the write is discarded, err stays 0.
REQ-030 During rst=1, FORWARD SHALL be suppressed; qa/qb reflect stored state.
REQ-031 No reset-independent initial value is relied on; first rst pulse defines state.

Structure
REQ-032 AW computation and the legal-DEPTH range check SHALL live in a shared include file of register-block constants, reused by other register blocks.
REQ-033 Each storage word SHALL be one instance of sub-module param_register (WIDTH, INIT; ports d, clk, rst, w, q), per-instance write enable decoded from w and wa.
REQ-034 Read muxing, forwarding and err logic SHALL be in register_file itself; no further sub-modules.

Verification (WIDTH=10, DEPTH=4, INIT=10'b1111100000 unless stated)
REQ-035 rst=1 one cycle, then read all addresses on both ports -> every read 10'b1111100000, err=0.
REQ-036 Write 45 to reg 1, then 54 to reg 2, w=0 with d=100 on reg 1 -> reg1=45, reg2=54, reg1 unchanged after w=0 cycle.
REQ-037 FORWARD=1: w=1, wa=3, d=101, ra=3, rb=2 same cycle -> qa=101 before edge, qb=stored reg2; FORWARD=0 rerun -> qa=old reg3 until edge, then 101.
REQ-038 ZERO_REG=1: write 105 to address 0 -> qa at ra=0 stays 0, err=1 next cycle only, other registers unchanged.
REQ-039 DEPTH=3: write 7 to address 3 -> no register changes, err=1 for one cycle; read address 3 -> 0.
REQ-040 rst=1 with w=1, wa=1, d=0 same edge -> reg1=INIT, err=0; next cycle write 0 to reg1 with rst=0 -> reg1=0.
